// File: rtl/spi_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_arbiter_pkg
// Description : Shared types and constants for the SPI arbiter and its shifter
// Revision    : 1.0
// ============================================================================
package spi_arbiter_pkg;

    localparam int c_LEN_W     = 5;
    localparam int c_GAP_TICKS = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_LOW   = 3'd1,
        ST_CLK_LOW  = 3'd2,
        ST_CLK_HIGH = 3'd3,
        ST_CS_HIGH  = 3'd4,
        ST_GAP      = 3'd5
    } SPI_ARB_STATE;

endpackage
`default_nettype wire

// File: rtl/spi_shifter.sv
`default_nettype none
// ============================================================================
// Module      : spi_shifter
// Description : Tick generator, nCS/SClk sequencing and shift register (mode 3)
// Revision    : 1.0
// ============================================================================
module spi_shifter
    import spi_arbiter_pkg::*;
#(
    parameter int CLOCK_DIV = 5,
    parameter int MAX_BITS  = 24
) (
    input  logic                ipClk,
    input  logic                Reset,
    input  logic                i_start,
    input  logic [c_LEN_W-1:0]  i_len,
    input  logic [MAX_BITS-1:0] i_tx,
    input  logic                i_sdo,
    output logic                o_tick,
    output logic                o_idle,
    output logic                o_done,
    output logic [MAX_BITS-1:0] o_rx,
    output logic                o_ncs,
    output logic                o_sclk,
    output logic                o_sdi
);

    localparam int                c_TW       = $clog2(CLOCK_DIV + 1);
    localparam logic [c_TW-1:0]   c_TICK_MAX = c_TW'(CLOCK_DIV);
    localparam logic [c_TW-1:0]   c_TICK_ONE = c_TW'(1);
    localparam logic [c_LEN_W-1:0] c_CNT_ONE = c_LEN_W'(1);

    SPI_ARB_STATE        r_state;
    SPI_ARB_STATE        w_state_nxt;
    logic [c_TW-1:0]     r_tcnt;
    logic                w_tick;
    logic [c_LEN_W-1:0]  r_cnt;
    logic [c_LEN_W-1:0]  r_len;
    logic [MAX_BITS-1:0] r_sr;
    logic [MAX_BITS-1:0] r_rx;
    logic [MAX_BITS-1:0] w_mask;
    logic                r_done;
    logic                r_ncs;
    logic                r_sclk;
    logic                r_sdi;

    assign w_tick = (r_tcnt == c_TICK_MAX);

    always_ff @(posedge ipClk) begin
        if (Reset || w_tick) r_tcnt <= c_TICK_ONE;
        else                 r_tcnt <= r_tcnt + c_TICK_ONE;
    end

    always_ff @(posedge ipClk) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            case (r_state)
                ST_IDLE:     if (i_start) w_state_nxt = ST_CS_LOW;
                ST_CS_LOW:   w_state_nxt = (r_cnt == '0) ? ST_CS_HIGH : ST_CLK_LOW;
                ST_CLK_LOW:  w_state_nxt = ST_CLK_HIGH;
                ST_CLK_HIGH: w_state_nxt = (r_cnt == c_CNT_ONE) ? ST_CS_HIGH : ST_CLK_LOW;
                ST_CS_HIGH:  w_state_nxt = ST_GAP;
                ST_GAP:      if (r_cnt == '0) w_state_nxt = ST_IDLE;
                default:     w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Only the bits actually clocked in are returned; the rest of the word is stale tx data.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_BITS; i++) w_mask[i] = (i < int'(r_len));
    end

    always_ff @(posedge ipClk) begin
        if (Reset) begin
            r_cnt  <= '0;
            r_len  <= '0;
            r_sr   <= '0;
            r_rx   <= '0;
            r_done <= 1'b0;
            r_ncs  <= 1'b1;
            r_sclk <= 1'b1;
            r_sdi  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_sr  <= i_tx;
                            r_cnt <= i_len;
                            r_len <= i_len;
                        end
                    end
                    ST_CS_LOW:  r_ncs <= 1'b0;
                    ST_CLK_LOW: begin
                        r_sclk <= 1'b0;
                        r_sdi  <= r_sr[MAX_BITS-1];
                    end
                    ST_CLK_HIGH: begin
                        r_sclk <= 1'b1;
                        r_sr   <= {r_sr[MAX_BITS-2:0], i_sdo};
                        r_cnt  <= r_cnt - c_CNT_ONE;
                    end
                    ST_CS_HIGH: begin
                        r_ncs  <= 1'b1;
                        r_sdi  <= 1'b1;
                        r_rx   <= r_sr & w_mask;
                        r_done <= 1'b1;
                        r_cnt  <= c_LEN_W'(c_GAP_TICKS - 1);
                    end
                    ST_GAP:  if (r_cnt != '0) r_cnt <= r_cnt - c_CNT_ONE;
                    default: r_ncs <= 1'b1;
                endcase
            end
        end
    end

    assign o_tick = w_tick;
    assign o_idle = (r_state == ST_IDLE);
    assign o_done = r_done;
    assign o_rx   = r_rx;
    assign o_ncs  = r_ncs;
    assign o_sclk = r_sclk;
    assign o_sdi  = r_sdi;

endmodule
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_arbiter
// Description : Round-robin sharing of one mode-3 SPI master among N_REQ
//               requesters. Define SPI_ARB_PRIORITY_EN to give requester 0
//               absolute priority over the others.
// Revision    : 1.0
// ============================================================================
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int Clock_Div = 5,
    parameter int MAX_BITS  = 24
) (
    input  logic                      ipClk,
    input  logic                      Reset,
    input  logic [N_REQ-1:0]          ipReq,
    input  logic [N_REQ*c_LEN_W-1:0]  ipLength,
    input  logic [N_REQ*MAX_BITS-1:0] ipTxData,
    output logic [N_REQ-1:0]          opGrant,
    output logic [N_REQ-1:0]          opDone,
    output logic [MAX_BITS-1:0]       opRxData,
    output logic                      opBusy,
    output logic                      nCS,
    output logic                      SClk,
    output logic                      SDI,
    input  logic                      SDO
);

    localparam int c_IW = $clog2(N_REQ);
`ifdef SPI_ARB_PRIORITY_EN
    localparam bit c_PRIO_EN = 1'b1;
`else
    localparam bit c_PRIO_EN = 1'b0;
`endif

    logic [c_IW-1:0]     r_last;
    logic [c_IW-1:0]     r_owner;
    logic [N_REQ-1:0]    r_grant;
    logic [c_IW-1:0]     w_win;
    logic [c_IW-1:0]     w_cand;
    logic                w_found;
    logic                w_tick;
    logic                w_idle;
    logic                w_start;
    logic                w_done;
    logic [c_LEN_W-1:0]  w_len_raw;
    logic [c_LEN_W-1:0]  w_len;
    logic [MAX_BITS-1:0] w_tx;

    // Search starts one past the last winner; with priority, requester 0 is
    // taken out of the rotation and checked first.
    always_comb begin
        w_win   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        if (c_PRIO_EN && ipReq[0]) w_found = 1'b1;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = c_IW'((int'(r_last) + k) % N_REQ);
            if (!w_found && ipReq[w_cand] && !(c_PRIO_EN && w_cand == '0)) begin
                w_win   = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign w_start   = w_tick && w_idle && (|ipReq);
    assign w_len_raw = ipLength[int'(w_win)*c_LEN_W +: c_LEN_W];
    assign w_len     = (w_len_raw > c_LEN_W'(MAX_BITS)) ? c_LEN_W'(MAX_BITS) : w_len_raw;
    assign w_tx      = ipTxData[int'(w_win)*MAX_BITS +: MAX_BITS];

    always_ff @(posedge ipClk) begin
        if (Reset) begin
            r_last  <= c_IW'(N_REQ - 1);
            r_owner <= '0;
            r_grant <= '0;
        end else begin
            r_grant <= '0;
            if (w_start) begin
                r_grant <= N_REQ'(1) << w_win;
                r_owner <= w_win;
                if (!(c_PRIO_EN && w_win == '0)) r_last <= w_win;
            end
        end
    end

    spi_shifter #(
        .CLOCK_DIV (Clock_Div),
        .MAX_BITS  (MAX_BITS)
    ) u_shifter (
        .ipClk   (ipClk),
        .Reset   (Reset),
        .i_start (w_start),
        .i_len   (w_len),
        .i_tx    (w_tx),
        .i_sdo   (SDO),
        .o_tick  (w_tick),
        .o_idle  (w_idle),
        .o_done  (w_done),
        .o_rx    (opRxData),
        .o_ncs   (nCS),
        .o_sclk  (SClk),
        .o_sdi   (SDI)
    );

    assign opGrant = r_grant;
    assign opDone  = w_done ? (N_REQ'(1) << r_owner) : '0;
    assign opBusy  = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_arbiter
// Description : Self-checking bench for spi_arbiter (vector table, corner
//               sequences, randomized rounds against a behavioural model)
// Revision    : 1.0
// ============================================================================
module tb_spi_arbiter;

    localparam int N  = 3;
    localparam int CD = 5;
    localparam int MB = 24;

    logic            ipClk = 1'b0;
    logic            Reset = 1'b1;
    logic [N-1:0]    ipReq = '0;
    logic [N*5-1:0]  ipLength = '0;
    logic [N*MB-1:0] ipTxData = '0;
    logic [N-1:0]    opGrant;
    logic [N-1:0]    opDone;
    logic [MB-1:0]   opRxData;
    logic            opBusy;
    logic            nCS;
    logic            SClk;
    logic            SDI;
    logic            SDO = 1'b1;

    spi_arbiter #(.N_REQ(N), .Clock_Div(CD), .MAX_BITS(MB)) dut (
        .ipClk(ipClk), .Reset(Reset), .ipReq(ipReq), .ipLength(ipLength),
        .ipTxData(ipTxData), .opGrant(opGrant), .opDone(opDone),
        .opRxData(opRxData), .opBusy(opBusy), .nCS(nCS), .SClk(SClk),
        .SDI(SDI), .SDO(SDO)
    );

    initial forever #5 ipClk = ~ipClk;

    // Slave: presents slv_word MSB-first, changing SDO on SClk falling edges.
    logic [MB-1:0] slv_word = '0;
    int            sbit = 0;
    always @(negedge SClk or posedge nCS) begin
        if (nCS) sbit <= 0;
        else begin
            SDO  <= slv_word[MB-1-sbit];
            sbit <= sbit + 1;
        end
    end

    // Bus monitor: nCS low/high durations in cycles, SClk rises and SDI bits.
    int            mcyc = 0, low_start = 0, high_start = 0;
    int            last_low_len = 0, last_gap = 0, sclk_rises = 0;
    logic          prev_ncs = 1'b1, prev_sclk = 1'b1;
    logic [MB-1:0] sdi_cap = '0;
    always @(negedge ipClk) begin
        mcyc = mcyc + 1;
        if (prev_ncs && !nCS) begin
            last_gap   = mcyc - high_start;
            low_start  = mcyc;
            sclk_rises = 0;
            sdi_cap    = '0;
        end
        if (!prev_ncs && nCS) begin
            last_low_len = mcyc - low_start;
            high_start   = mcyc;
        end
        if (!prev_sclk && SClk && !nCS) begin
            sclk_rises = sclk_rises + 1;
            sdi_cap    = {sdi_cap[MB-2:0], SDI};
        end
        prev_ncs  = nCS;
        prev_sclk = SClk;
    end

    initial begin
        repeat (90000) @(posedge ipClk);
        $display("FAIL watchdog: simulation still running after 90000 cycles");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_err = 0;
    int tcyc  = 0;
    int model_last = N - 1;

    task automatic step();
        @(negedge ipClk);
        #1;
        tcyc++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // kind 0: grant, 1: done, 2: idle, 3: nCS low with at least thr SClk rises
    task automatic wait_evt(input int kind, input int thr, input string nm);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 4000) begin
            step();
            n++;
            case (kind)
                0:       hit = (opGrant != '0);
                1:       hit = (opDone != '0);
                2:       hit = !opBusy;
                default: hit = !nCS && (sclk_rises >= thr);
            endcase
        end
        if (!hit) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: event not seen within %0d cycles", nm, n);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference arbitration: next pending requester after the last winner.
    function automatic int model_pick(input logic [N-1:0] pend);
`ifdef SPI_ARB_PRIORITY_EN
        if (pend[0]) return 0;
        for (int k = 1; k < N; k++) begin
            int c = ((model_last - 1 + k) % (N - 1)) + 1;
            if (pend[c]) begin
                model_last = c;
                return c;
            end
        end
`else
        for (int k = 1; k <= N; k++) begin
            int c = (model_last + k) % N;
            if (pend[c]) begin
                model_last = c;
                return c;
            end
        end
`endif
        return -1;
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        ipReq = '0;
        repeat (2) step();
        Reset = 1'b0;
        model_last = N - 1;
    endtask

    typedef struct {
        int            idx;
        int            len;
        logic [MB-1:0] tx;
        logic [MB-1:0] slv;
        logic [MB-1:0] exp_rx;
        logic [MB-1:0] exp_sdi;
        int            exp_ticks;
        int            exp_low;
        int            exp_bits;
    } tv_t;

    tv_t tv[5];

    initial begin
        int            gc, dc, exp_i, got, le;
        logic [N-1:0]  pend;
        int            lens[N];
        logic [MB-1:0] txs[N];
        logic [MB-1:0] slvs[N];
        int            n;
        bit            saw_done;

        tv[0] = '{0, 16, 24'h310900, 24'h5A5A00, 24'h005A5A, 24'h003109, 34, 33, 16};
        tv[1] = '{1, 24, 24'hF20000, 24'h00CDAB, 24'h00CDAB, 24'hF20000, 50, 49, 24};
        tv[2] = '{2,  0, 24'hABCDEF, 24'hFFFFFF, 24'h000000, 24'h000000,  2,  1,  0};
        tv[3] = '{1, 31, 24'hA5A5A5, 24'h123456, 24'h123456, 24'hA5A5A5, 50, 49, 24};
        tv[4] = '{0,  1, 24'h800000, 24'hFFFFFF, 24'h000001, 24'h000001,  4,  3,  1};

        repeat (3) step();
        check("rst nCS", nCS, 1);
        check("rst SClk", SClk, 1);
        check("rst SDI", SDI, 1);
        check("rst opGrant", opGrant, 0);
        check("rst opDone", opDone, 0);
        check("rst opRxData", opRxData, 0);
        check("rst opBusy", opBusy, 0);
        Reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            ipLength[tv[v].idx*5 +: 5]  = 5'(tv[v].len);
            ipTxData[tv[v].idx*MB +: MB] = tv[v].tx;
            slv_word = tv[v].slv;
            ipReq[tv[v].idx] = 1'b1;
            wait_evt(0, 0, "tv grant wait");
            check($sformatf("tv%0d grant", v), opGrant, 1 << tv[v].idx);
            gc = tcyc;
            ipReq[tv[v].idx] = 1'b0;
            wait_evt(1, 0, "tv done wait");
            check($sformatf("tv%0d done", v), opDone, 1 << tv[v].idx);
            check($sformatf("tv%0d rx", v), opRxData, tv[v].exp_rx);
            check($sformatf("tv%0d grant-to-done cycles", v), tcyc - gc, tv[v].exp_ticks * CD);
            check($sformatf("tv%0d nCS low cycles", v), last_low_len, tv[v].exp_low * CD);
            check($sformatf("tv%0d SClk rises", v), sclk_rises, tv[v].exp_bits);
            check($sformatf("tv%0d SDI bits", v), sdi_cap, tv[v].exp_sdi);
            wait_evt(2, 0, "tv idle wait");
        end

        // Fairness with all requests held.
        do_reset();
        for (int i = 0; i < N; i++) ipLength[i*5 +: 5] = 5'd2;
        ipReq = '1;
        for (int k = 0; k < 6; k++) begin
            exp_i = model_pick('1);
            wait_evt(0, 0, "fair grant wait");
            check($sformatf("fair grant %0d", k), idx_of(opGrant), exp_i);
            if (k > 0) begin
                wait_evt(3, 0, "fair nCS wait");
                check($sformatf("fair gap>=2 ticks %0d", k), (last_gap >= 2 * CD), 1);
            end
        end
        ipReq = '0;
        wait_evt(2, 0, "fair idle wait");

        // Late request arriving mid-transaction.
        ipLength[0 +: 5]  = 5'd8;
        ipTxData[0 +: MB] = 24'hC30000;
        slv_word = 24'h9F0000;
        ipReq[0] = 1'b1;
        wait_evt(0, 0, "late grant0 wait");
        ipReq[0] = 1'b0;
        wait_evt(3, 2, "late mid wait");
        ipLength[10 +: 5]    = 5'd3;
        ipTxData[2*MB +: MB] = 24'hE00000;
        ipReq[2] = 1'b1;
        wait_evt(1, 0, "late done0 wait");
        check("late done0", opDone, 3'b001);
        check("late rx0", opRxData, 24'h00009F);
        dc = tcyc;
        wait_evt(0, 0, "late grant2 wait");
        check("late grant2", opGrant, 3'b100);
        check("late done-to-grant cycles", tcyc - dc, 2 * CD);
        ipReq[2] = 1'b0;
        slv_word = 24'h600000;
        wait_evt(1, 0, "late done2 wait");
        check("late done2", opDone, 3'b100);
        check("late rx2", opRxData, 24'h000003);
        check("late sdi2", sdi_cap, 24'h000007);
        wait_evt(2, 0, "late idle wait");

        // Reset at bit 10 of a 24-bit transfer by requester 1.
        ipLength[5 +: 5]  = 5'd24;
        ipTxData[MB +: MB] = 24'h5AC3F0;
        ipReq[1] = 1'b1;
        wait_evt(0, 0, "rst grant wait");
        ipReq[1] = 1'b0;
        wait_evt(3, 10, "rst bit10 wait");
        Reset = 1'b1;
        step();
        check("midrst nCS", nCS, 1);
        check("midrst SClk", SClk, 1);
        check("midrst SDI", SDI, 1);
        check("midrst opDone", opDone, 0);
        check("midrst opBusy", opBusy, 0);
        step();
        Reset = 1'b0;
        ipReq = '1;
        n = 0;
        saw_done = 1'b0;
        while (opGrant == '0 && n < 500) begin
            step();
            n++;
            if (opDone != '0) saw_done = 1'b1;
        end
        check("midrst no done", saw_done, 0);
        check("midrst first grant", opGrant, 3'b001);
        ipReq = '0;
        wait_evt(2, 0, "midrst idle wait");

        // Randomized rounds of simultaneous requests.
        do_reset();
        for (int r = 0; r < 12; r++) begin
            pend = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                lens[i] = $urandom_range(0, 31);
                txs[i]  = MB'($urandom);
                slvs[i] = MB'($urandom);
                ipLength[i*5 +: 5]  = 5'(lens[i]);
                ipTxData[i*MB +: MB] = txs[i];
            end
            ipReq = pend;
            while (pend != '0) begin
                exp_i = model_pick(pend);
                wait_evt(0, 0, "rnd grant wait");
                got = idx_of(opGrant);
                check($sformatf("rnd%0d grant", r), got, exp_i);
                if (got < 0) break;
                pend[got]  = 1'b0;
                ipReq[got] = 1'b0;
                slv_word   = slvs[got];
                wait_evt(1, 0, "rnd done wait");
                le = (lens[got] > MB) ? MB : lens[got];
                check($sformatf("rnd%0d done", r), opDone, 1 << got);
                check($sformatf("rnd%0d rx len%0d", r, le), opRxData, slvs[got] >> (MB - le));
                check($sformatf("rnd%0d sdi len%0d", r, le), sdi_cap, txs[got] >> (MB - le));
            end
            ipReq = '0;
            wait_evt(2, 0, "rnd idle wait");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_arbiter.md
# spi_arbiter

Shares one 4-wire SPI master (mode 3, SClk idle high) between `N_REQ` on-chip requesters, such as an accelerometer poller, a configuration loader and a debug port. Each requester submits a complete transaction of up to `MAX_BITS` bits. The arbiter grants requesters round-robin and runs the transaction on the shared `nCS`/`SClk`/`SDI`/`SDO` pins. It returns the received bits to the granted requester and enforces a minimum `nCS` high gap between transactions. It sits between the sensor-facing pins and all SPI-using blocks, so it is the only driver of the SPI bus.

## Interface
Parameters:
- `N_REQ`, 3, number of requesters (2..8).
- `Clock_Div`, 5, ipClk cycles per SPI tick; SClk frequency = ipClk / (2·`Clock_Div`).
- `MAX_BITS`, 24, maximum transaction length in bits.

Ports:
- `ipClk`  in  1  clock.
- `Reset`  in  1  synchronous, active-high; clock `ipClk`.
- `ipReq`  in  N_REQ  per-requester request level.
- `ipLength`  in  N_REQ·5  per-requester bit count, slice i = [5i+4:5i].
- `ipTxData`  in  N_REQ·MAX_BITS  per-requester transmit word, MSB-aligned; bit MAX_BITS-1 is sent first.
- `opGrant`  out  N_REQ  one-cycle pulse when the request is latched.
- `opDone`  out  N_REQ  one-cycle pulse when the transaction is complete.
- `opRxData`  out  MAX_BITS  received bits, right-justified; valid from the `opDone` cycle until the next `opDone`.
- `opBusy`  out  1  high from grant until return to Idle.
- `nCS`, `SClk`, `SDI`  out  1  SPI pins.
- `SDO`  in  1  SPI data from the slave.

## Operation
- Tick counter: counts 1..`Clock_Div`; `Tick` is asserted when the count equals `Clock_Div`. All state changes occur only on `Tick`, except that `opGrant` and `opDone` last exactly one ipClk cycle.
- States: Idle, CsLow, ClkLow, ClkHigh, CsHigh, Gap.
- Idle: on `Tick` with any `ipReq` set, choose a winner by round-robin starting at last winner + 1 (wrapping at `N_REQ`).
  - Latch the winner's `ipTxData`, its length (saturated to `MAX_BITS`) and its index.
  - Pulse `opGrant[winner]`, set `opBusy`, go to CsLow.
- Request handshake:
  - `ipReq[i]` must remain asserted until `opGrant[i]`.
  - Data is latched at grant; the requester may change its inputs afterwards.
  - A request dropped before grant is ignored without error.
- CsLow: `nCS`←0, go to ClkLow. If the latched length is 0, go directly to CsHigh instead; `opRxData` is then 0.
- ClkLow: `SClk`←0, `SDI`←shift-register MSB, go to ClkHigh.
- ClkHigh: `SClk`←1, shift the shift register left by one with `SDO` entering the LSB, decrement the count. If the count reaches 0, go to CsHigh; otherwise go to ClkLow.
- CsHigh: `nCS`←1, `SDI`←1. `opRxData`←low `Length` bits of the shift register, upper bits zeroed. Pulse `opDone[owner]`, go to Gap.
- Gap: one tick with `nCS` high, then Idle; `opBusy` falls on entry to Idle.
- A new request arriving during a transaction waits; it is evaluated at the first Idle `Tick`.
- Simultaneous requests are served in round-robin order; the same requester cannot win twice while another is pending.

## Timing
- Reset values: `nCS`=1, `SClk`=1, `SDI`=1, `opGrant`=0, `opDone`=0, `opRxData`=0, `opBusy`=0, state Idle, last winner = `N_REQ`-1 (so requester 0 wins first).
- Reset mid-transaction: all pins return to idle on the next ipClk. No `opDone` is issued. The transaction is discarded; the requester must re-request.
- Latency, measured in ticks from the grant tick:
  - `nCS` falls at +1; first SClk falling edge at +2.
  - `opDone` at +2·Length+2; next grant possible at +2·Length+4.
- `SDI` changes only on SClk falling edges. `SDO` is sampled on the tick that drives SClk high.
- `nCS` is low for 2·Length+1 ticks, and high for at least 2 ticks between transactions.

## Configuration
- `SPI_ARB_PRIORITY_EN`:
  - Defined: requester 0 has absolute priority and wins whenever `ipReq[0]` is set at an Idle tick. Requesters 1..`N_REQ`-1 are round-robin among themselves. Starvation of the others is permitted.
  - Undefined: pure round-robin over all requesters.

## Structure
- Package `spi_arbiter_pkg`:
  - State enum `SPI_ARB_STATE`.
  - Length width constant (5).
  - Gap length constant (1 tick).
- Sub-module `spi_shifter`:
  - Contains the tick counter, the CsLow..Gap sequencing and the shift register.
  - Interface: start, length, tx word in; done pulse, rx word out.
- `spi_arbiter` contains round-robin selection, request latching, owner tracking and the grant/done fan-out.

## Test plan
- Single write: req0, Length 16, TxData 0x310900, `Clock_Div`=5.
  - SDI carries 0x3109 MSB-first; `nCS` is low for 33 ticks.
  - `opDone[0]` arrives 34 ticks after `opGrant[0]`.
- Read: req1, Length 24, TxData 0xF20000; SDO model returns 0x00 then 0xCDAB.
  - `opRxData`=0x00CDAB at `opDone[1]`.
- Fairness: `ipReq`=3'b111 held continuously.
  - Grant order 0,1,2,0,1,2; `nCS` high for ≥2 ticks between each.
  - With `SPI_ARB_PRIORITY_EN` defined, the order is 0,0,0.
- Length 0: req2, Length 0.
  - No SClk edges; `nCS` low for exactly 1 tick; `opDone[2]` with `opRxData`=0.
- Reset at bit 10 of a 24-bit transaction:
  - Next cycle `nCS`=`SClk`=`SDI`=1, no `opDone`.
  - After release, req0 is granted first.
- Late request: req2 raised during req0's transaction.
  - Granted at the first Idle tick after Gap; req0's `opDone` is unaffected.
